// File: rtl/mem_bank_pkg.sv
// Shared types and encodings for the per-bank atomic adapter.
// MEM_BANK_ATOP_MINMAX_EN selects whether the SMAX/SMIN/UMAX/UMIN ops are supported.
package mem_bank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      AMO_RD = 2'd1,
      AMO_WR = 2'd2
   } state_t;

   localparam logic [1:0] ATOP_NONE  = 2'b00;
   localparam logic [1:0] ATOP_STORE = 2'b01;
   localparam logic [1:0] ATOP_LOAD  = 2'b10;
   localparam logic [5:0] ATOP_SWAP  = 6'b110000;
   localparam logic [5:0] ATOP_CMP   = 6'b110001;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_CLR  = 3'b001;
   localparam logic [2:0] OP_EOR  = 3'b010;
   localparam logic [2:0] OP_SET  = 3'b011;
   localparam logic [2:0] OP_SMAX = 3'b100;
   localparam logic [2:0] OP_SMIN = 3'b101;
   localparam logic [2:0] OP_UMAX = 3'b110;
   localparam logic [2:0] OP_UMIN = 3'b111;

   // Endianness bit atop[3] is ignored throughout.
   function automatic logic is_swap(input logic [5:0] atop);
      return (atop[5:4] == ATOP_SWAP[5:4]) && (atop[2:0] == ATOP_SWAP[2:0]);
   endfunction

   // True for requests that need the read-modify-write sequence; compare is excluded.
   function automatic logic is_atomic(input logic we, input logic [5:0] atop);
      return we && ((atop[5:4] == ATOP_STORE) || (atop[5:4] == ATOP_LOAD) || is_swap(atop));
   endfunction

   function automatic logic op_supported(input logic [2:0] op);
`ifdef MEM_BANK_ATOP_MINMAX_EN
      return (op == op);
`else
      return !op[2];
`endif
   endfunction

endpackage

// File: rtl/mem_atop_alu.sv
// Combinational AXI5 atomic ALU; min/max ops exist only with MEM_BANK_ATOP_MINMAX_EN.
module mem_atop_alu
   import mem_bank_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic [DataWidth-1:0] old,
   input  logic [DataWidth-1:0] operand,
   input  logic [2:0]           op,
   input  logic                 swap,
   output logic [DataWidth-1:0] result
);

   always_comb begin
      result = operand;
      if (!swap) begin
         case (op)
            OP_ADD:  result = old + operand;
            OP_CLR:  result = old & ~operand;
            OP_EOR:  result = old ^ operand;
            OP_SET:  result = old | operand;
`ifdef MEM_BANK_ATOP_MINMAX_EN
            OP_SMAX: result = ($signed(old) > $signed(operand)) ? old : operand;
            OP_SMIN: result = ($signed(old) < $signed(operand)) ? old : operand;
            OP_UMAX: result = (old > operand) ? old : operand;
            OP_UMIN: result = (old < operand) ? old : operand;
`endif
            default: result = old;
         endcase
      end
   end

endmodule

// File: rtl/mem_bank_atop_adapter.sv
// Per-bank SRAM adapter: plain requests pass through, atomics run IDLE -> AMO_RD -> AMO_WR.
// MEM_BANK_ATOP_MINMAX_EN enables the min/max atomic ops.
module mem_bank_atop_adapter
   import mem_bank_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int StrbWidth = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [StrbWidth-1:0] strb_i,
   input  logic                 we_i,
   input  logic [5:0]           atop_i,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [StrbWidth-1:0] sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   // Handshake: a request is accepted in a cycle where req_i and gnt_o are both high.
   state_t               state_q, state_d;
   logic [AddrWidth-1:0] addr_q;
   logic [DataWidth-1:0] operand_q, old_q, alu_result;
   logic [StrbWidth-1:0] strb_q;
   logic [1:0]           cls_q;
   logic [2:0]           op_q;
   logic                 swap_q;
   logic                 rvalid_q, rd_q;
   logic                 amo_writes;

   mem_atop_alu #(.DataWidth(DataWidth)) u_alu (
      .old     (sram_rdata_i),
      .operand (operand_q),
      .op      (op_q),
      .swap    (swap_q),
      .result  (alu_result)
   );

   assign amo_writes = swap_q || op_supported(op_q);

   always_comb begin
      state_d      = state_q;
      gnt_o        = 1'b0;
      rvalid_o     = 1'b0;
      rdata_o      = '0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               gnt_o    = 1'b1;
               rvalid_o = rvalid_q;
               if (rvalid_q && rd_q) rdata_o = sram_rdata_i;
               if (req_i) begin
                  // Atomics and compares read first; only plain writes write here.
                  sram_req_o   = 1'b1;
                  sram_we_o    = we_i && (atop_i[5:4] == ATOP_NONE);
                  sram_addr_o  = addr_i;
                  sram_wdata_o = wdata_i;
                  sram_be_o    = strb_i;
                  if (is_atomic(we_i, atop_i)) state_d = AMO_RD;
               end
            end
            AMO_RD: begin
               sram_req_o   = amo_writes;
               sram_we_o    = amo_writes;
               sram_addr_o  = addr_q;
               sram_wdata_o = alu_result;
               sram_be_o    = strb_q;
               state_d      = AMO_WR;
            end
            AMO_WR: begin
               rvalid_o = 1'b1;
               rdata_o  = ((cls_q == ATOP_STORE) && amo_writes) ? '0 : old_q;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         operand_q <= '0;
         old_q     <= '0;
         strb_q    <= '0;
         cls_q     <= '0;
         op_q      <= '0;
         swap_q    <= 1'b0;
         rvalid_q  <= 1'b0;
         rd_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= (state_q == IDLE) && req_i && !is_atomic(we_i, atop_i);
         rd_q     <= !(we_i && (atop_i[5:4] == ATOP_NONE));
         if ((state_q == IDLE) && req_i && is_atomic(we_i, atop_i)) begin
            addr_q    <= addr_i;
            operand_q <= wdata_i;
            strb_q    <= strb_i;
            cls_q     <= atop_i[5:4];
            op_q      <= atop_i[2:0];
            swap_q    <= is_swap(atop_i);
         end
         if (state_q == AMO_RD) old_q <= sram_rdata_i;
      end
   end

endmodule
